// File: rtl/glyph_row_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : glyph_row_serializer_if
// Purpose  : Request handshake bundle for glyph_row_serializer.
//            req_inv exists only when GLYPH_INVERT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface glyph_row_serializer_if #(
  parameter int CODE_W = 3,
  parameter int ROW_W  = 4
) ();
  logic              req_valid;
  logic              req_ready;
  logic [CODE_W-1:0] req_code;
  logic [ROW_W-1:0]  req_row;
`ifdef GLYPH_INVERT_EN
  logic              req_inv;

  modport master (
    output req_valid,
    output req_code,
    output req_row,
    output req_inv,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_code,
    input  req_row,
    input  req_inv,
    output req_ready
  );
`else
  modport master (
    output req_valid,
    output req_code,
    output req_row,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_code,
    input  req_row,
    output req_ready
  );
`endif
endinterface
`default_nettype wire

// File: rtl/glyph_row_serializer.sv
`default_nettype none
// ============================================================================
// Module   : glyph_row_serializer
// Purpose  : Fetches glyph rows from a synchronous ROM into a one-entry hold
//            register and shifts them out MSB-first on pixel enables.
//            Define GLYPH_INVERT_EN to add per-request reverse video.
// Revision : 1.0 - initial release
// ============================================================================
module glyph_row_serializer #(
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 16,
  parameter int CODE_W    = 3,
  parameter int ROW_W     = 4,
  parameter int NUM_CHARS = 4
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  glyph_row_serializer_if.slave        req_if,
  output logic                         o_rom_en,
  output logic [CODE_W+ROW_W-1:0]      o_rom_addr,
  input  wire logic [CHAR_W-1:0]       i_rom_data,
  input  wire logic                    i_pix_en,
  output logic                         o_pix_out,
  output logic                         o_pix_valid,
  output logic                         o_underrun
);

  localparam int               CNT_W       = $clog2(CHAR_W + 1);
  localparam logic [CODE_W:0]  c_num_chars = (CODE_W+1)'(NUM_CHARS);
  localparam logic [ROW_W:0]   c_char_h    = (ROW_W+1)'(CHAR_H);
  localparam logic [CNT_W-1:0] c_cnt_full  = CNT_W'(CHAR_W);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  state_t                     r_state;
  logic                       r_alive;
  logic                       r_blank;
  logic                       r_rom_en;
  logic [CODE_W+ROW_W-1:0]    r_rom_addr;
  logic [CHAR_W-1:0]          r_hold;
  logic                       r_hold_full;
  logic [CHAR_W-1:0]          r_sr;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_underrun;
`ifdef GLYPH_INVERT_EN
  logic                       r_inv;
`endif

  logic                       w_req_ready;
  logic                       w_accept;
  logic                       w_blank;
  logic                       w_load;
  logic [CHAR_W-1:0]          w_rom_row;
  logic [CHAR_W-1:0]          w_capt_row;

  // r_alive keeps req_ready low until the first edge after reset release.
  assign w_req_ready = r_alive & (r_state == S_IDLE) & ~r_hold_full;
  assign w_accept    = req_if.req_valid & w_req_ready;
  assign w_blank     = ({1'b0, req_if.req_code} >= c_num_chars) |
                       ({1'b0, req_if.req_row}  >= c_char_h);

  // Load when the shifter is empty, or gaplessly on its last pixel.
  assign w_load = r_hold_full &
                  ((r_cnt == '0) | (i_pix_en & (r_cnt == c_cnt_one)));

  assign w_rom_row = r_blank ? '0 : i_rom_data;
`ifdef GLYPH_INVERT_EN
  assign w_capt_row = r_inv ? ~w_rom_row : w_rom_row;
`else
  assign w_capt_row = w_rom_row;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alive     <= 1'b0;
      r_blank     <= 1'b0;
      r_rom_en    <= 1'b0;
      r_rom_addr  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
`ifdef GLYPH_INVERT_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      r_alive <= 1'b1;
      if (w_load) begin
        r_hold_full <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_READ;
            r_blank    <= w_blank;
            r_rom_en   <= ~w_blank;
            r_rom_addr <= {req_if.req_code, req_if.req_row};
`ifdef GLYPH_INVERT_EN
            r_inv      <= req_if.req_inv;
`endif
          end
        end
        S_READ: begin
          r_state    <= S_CAPT;
          r_rom_en   <= 1'b0;
          r_rom_addr <= '0;
        end
        S_CAPT: begin
          // Hold is guaranteed empty here, so this cannot race a drain.
          r_hold      <= w_capt_row;
          r_hold_full <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_rom_en   <= 1'b0;
          r_rom_addr <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr       <= '0;
      r_cnt      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= i_pix_en & (r_cnt == '0) & ~r_hold_full;
      if (w_load) begin
        r_sr  <= r_hold;
        r_cnt <= c_cnt_full;
      end else if (i_pix_en && (r_cnt > c_cnt_one)) begin
        r_sr  <= r_sr << 1;
        r_cnt <= r_cnt - c_cnt_one;
      end else if (i_pix_en && (r_cnt == c_cnt_one)) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end
    end
  end

  assign req_if.req_ready = w_req_ready;
  assign o_rom_en         = r_rom_en;
  assign o_rom_addr       = r_rom_addr;
  assign o_pix_valid      = (r_cnt != '0);
  assign o_pix_out        = r_sr[CHAR_W-1] & o_pix_valid;
  assign o_underrun       = r_underrun;

endmodule
`default_nettype wire
